// File: rtl/imem_pkg.sv
// imem_pkg
//   Shared definitions for the instruction-memory responder:
//   - imem_state_t   : responder FSM states
//   - NOP_INSTR      : instruction returned whenever no response is presented
//   - WORDS_PER_LINE : 16-bit words per cache line
//   - addr_offset / addr_index / addr_tag : request address field extraction.
//     Addresses are byte addresses of 16-bit words, so bit 0 is the
//     alignment bit, bits [2:1] select the word in a line, the next
//     idx_w bits select the line and everything above is the tag.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL_REQ  = 2'd1,
        FILL_WAIT = 2'd2,
        RESP      = 2'd3
    } imem_state_t;

    localparam logic [15:0] NOP_INSTR      = 16'h0800;
    localparam int          WORDS_PER_LINE = 4;
    localparam int          LINE_LSB       = 3;

    function automatic logic [1:0] addr_offset(input logic [15:0] addr);
        return addr[2:1];
    endfunction

    // Returned zero-extended to 16 bits; caller keeps the low idx_w bits.
    function automatic logic [15:0] addr_index(input logic [15:0] addr,
                                               input int          idx_w);
        logic [15:0] mask;
        mask = (16'd1 << idx_w) - 16'd1;
        return (addr >> LINE_LSB) & mask;
    endfunction

    // Returned zero-extended to 16 bits; caller keeps the low tag bits.
    function automatic logic [15:0] addr_tag(input logic [15:0] addr,
                                             input int          idx_w);
        return addr >> (LINE_LSB + idx_w);
    endfunction

endpackage

// File: rtl/imem_line_store.sv
// imem_line_store
//   Tag, valid and data arrays of the direct-mapped instruction cache.
//   Ports:
//     clk, rst          : clock, synchronous active-low reset (clears valid only)
//     rd_index/rd_offset: combinational read address
//     rd_tag/rd_valid/rd_word : stored tag, valid bit and data word
//     wr_en             : write wr_data into word wr_offset of line wr_index
//     tag_we            : commit wr_tag to line wr_index and mark it valid
//     wr_index/wr_offset/wr_data/wr_tag : write port operands
module imem_line_store
    import imem_pkg::*;
#(
    parameter int LINES = 8,
    parameter int WORDS = WORDS_PER_LINE,
    parameter int TAG_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(LINES)-1:0] rd_index,
    input  logic [$clog2(WORDS)-1:0] rd_offset,
    output logic [TAG_W-1:0]         rd_tag,
    output logic                     rd_valid,
    output logic [15:0]              rd_word,
    input  logic                     wr_en,
    input  logic                     tag_we,
    input  logic [$clog2(LINES)-1:0] wr_index,
    input  logic [$clog2(WORDS)-1:0] wr_offset,
    input  logic [15:0]              wr_data,
    input  logic [TAG_W-1:0]         wr_tag
);

    logic [15:0]      data_mem [LINES*WORDS];
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [LINES-1:0] valid;

    assign rd_word  = data_mem[{rd_index, rd_offset}];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid[rd_index];

    // Only the valid bits carry reset; stale tags/data are harmless
    // because nothing is reported as a hit without its valid bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_index, wr_offset}] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// imem_responder
//   Responder side of the fetch / instruction-memory handshake with a small
//   direct-mapped read-only cache refilled word-serially from backing memory.
//   Ports:
//     clk, rst      : clock, synchronous active-low reset
//     Addr, Rd, Wr  : fetch request (Wr is unsupported and reported as err)
//     DataIn        : unused, tied off by the initiator
//     createdump    : reserved, no effect
//     DataOut       : returned instruction, NOP whenever Done=0
//     Done          : one-cycle response strobe per sampled request
//     Stall         : refill in progress
//     CacheHit      : response was served from the cache
//     Addr_latched  : address the current response belongs to
//     err           : misaligned or write request
//     mem_addr, mem_rd : backing word read, one mem_rd cycle per word
//     mem_data, mem_valid : backing read return
//
//   Handshake: a request is taken at any clock edge where the FSM is in
//   IDLE or RESP and Rd or Wr is high. Exactly one Done pulse answers each
//   taken request: one cycle later for a hit or an error, in the RESP cycle
//   for a miss. Requests presented during a refill are not taken; fetch
//   drops stale responses by comparing Addr_latched with its PC.
module imem_responder #(
    parameter int LINES          = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] DataIn,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic [15:0] Addr_latched,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_data,
    input  logic        mem_valid
);

    import imem_pkg::*;

    localparam int IDX_W = $clog2(LINES);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int TAG_W = 16 - IDX_W - OFF_W - 1;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    imem_state_t state;

    // Lookup fields of the incoming address.
    logic [15:0]      idx_full;
    logic [15:0]      tag_full;
    logic [1:0]       off_full;
    logic [IDX_W-1:0] lk_index;
    logic [TAG_W-1:0] lk_tag;
    logic [OFF_W-1:0] lk_offset;

    // Request captured at a miss; the whole fill works from these.
    logic [15:0]      req_addr;
    logic [IDX_W-1:0] req_index;
    logic [TAG_W-1:0] req_tag;
    logic [OFF_W-1:0] req_offset;
    logic [OFF_W-1:0] word_cnt;
    logic [OFF_W-1:0] next_word;
    logic [15:0]      resp_word;

    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic [15:0]      rd_word;
    logic             hit;
    logic             req_bad;
    logic             fill_we;
    logic             fill_last;
    logic             unused_bits;

    assign idx_full  = addr_index(Addr, IDX_W);
    assign tag_full  = addr_tag(Addr, IDX_W);
    assign off_full  = addr_offset(Addr);
    assign lk_index  = idx_full[IDX_W-1:0];
    assign lk_tag    = tag_full[TAG_W-1:0];
    assign lk_offset = off_full[OFF_W-1:0];

    assign unused_bits = ^{DataIn, createdump, idx_full[15:IDX_W], tag_full[15:TAG_W]};

    assign hit       = rd_valid && (rd_tag == lk_tag);
    assign req_bad   = Wr || Addr[0];
    assign next_word = word_cnt + OFF_W'(1);

    // A returned word is written only while waiting for it; mem_valid in
    // any other state is ignored. The tag (and valid) is committed with the
    // last word, so a conflicting line keeps its old tag until then.
    assign fill_we   = (state == FILL_WAIT) && mem_valid;
    assign fill_last = fill_we && (word_cnt == LAST_WORD);

    imem_line_store #(
        .LINES (LINES),
        .WORDS (WORDS_PER_LINE),
        .TAG_W (TAG_W)
    ) u_line_store (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (lk_index),
        .rd_offset (lk_offset),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_word   (rd_word),
        .wr_en     (fill_we),
        .tag_we    (fill_last),
        .wr_index  (req_index),
        .wr_offset (word_cnt),
        .wr_data   (mem_data),
        .wr_tag    (req_tag)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            Done         <= 1'b0;
            Stall        <= 1'b0;
            CacheHit     <= 1'b0;
            err          <= 1'b0;
            DataOut      <= NOP_INSTR;
            Addr_latched <= 16'h0000;
            mem_rd       <= 1'b0;
            mem_addr     <= 16'h0000;
            req_addr     <= 16'h0000;
            req_index    <= '0;
            req_tag      <= '0;
            req_offset   <= '0;
            word_cnt     <= '0;
            resp_word    <= 16'h0000;
        end else begin
            // Response strobes and the backing read strobe are single-cycle.
            Done     <= 1'b0;
            CacheHit <= 1'b0;
            err      <= 1'b0;
            DataOut  <= NOP_INSTR;
            mem_rd   <= 1'b0;

            case (state)
                // RESP behaves like IDLE for sampling so a new request can be
                // taken in the same cycle the miss response is presented.
                IDLE, RESP: begin
                    state <= IDLE;
                    if (Rd || Wr) begin
                        if (req_bad) begin
                            Done         <= 1'b1;
                            err          <= 1'b1;
                            Addr_latched <= Addr;
                        end else if (hit) begin
                            Done         <= 1'b1;
                            CacheHit     <= 1'b1;
                            DataOut      <= rd_word;
                            Addr_latched <= Addr;
                        end else begin
                            state      <= FILL_REQ;
                            Stall      <= 1'b1;
                            mem_rd     <= 1'b1;
                            mem_addr   <= {Addr[15:OFF_W+1], {OFF_W{1'b0}}, 1'b0};
                            req_addr   <= Addr;
                            req_index  <= lk_index;
                            req_tag    <= lk_tag;
                            req_offset <= lk_offset;
                            word_cnt   <= '0;
                        end
                    end
                end

                FILL_REQ: begin
                    state <= FILL_WAIT;
                end

                FILL_WAIT: begin
                    if (mem_valid) begin
                        if (word_cnt == req_offset) begin
                            resp_word <= mem_data;
                        end
                        if (word_cnt == LAST_WORD) begin
                            state        <= RESP;
                            Stall        <= 1'b0;
                            Done         <= 1'b1;
                            Addr_latched <= req_addr;
                            // The requested word may be the one arriving now.
                            DataOut      <= (req_offset == LAST_WORD) ? mem_data : resp_word;
                        end else begin
                            state    <= FILL_REQ;
                            word_cnt <= next_word;
                            mem_rd   <= 1'b1;
                            mem_addr <= {req_tag, req_index, next_word, 1'b0};
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
